// File: rtl/fetch_decode_buffer.sv
// IF->ID skid FIFO: holds fetched {pc, instr} pairs in order and presents the head to decode; optional FDB_ADEL_EN adds adelD.
// Latency: an entry pushed at edge N is visible on validD/instrD after that edge (registered, no IF->ID bypass).
// Backpressure: readyF drops when full (count only, no pop bypass); stallD holds the head; flushD empties.
module fetch_decode_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          validF,
    output logic          readyF,
    input  logic [AW-1:0] pcF,
    input  logic [DW-1:0] instrF,
    input  logic          flushD,
    input  logic          stallD,
    output logic          validD,
    output logic [AW-1:0] pcD,
    output logic [DW-1:0] instrD,
    output logic [AW-1:0] pcplus4D
`ifdef FDB_ADEL_EN
    ,
    output logic          adelD
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
`ifdef FDB_ADEL_EN
        logic          adel;
`endif
    } ent_t;

    ent_t          mem [DEPTH];
    ent_t          wr_ent;
    ent_t          head;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign readyF = (count != CW'(DEPTH));
    assign validD = (count != '0);
    assign push   = validF & readyF & ~flushD;
    assign pop    = validD & ~stallD & ~flushD;
    assign head   = mem[rd_ptr];

    // Misaligned fetches are turned into no-ops so the decoder never acts on them.
    always_comb begin
        wr_ent       = '0;
        wr_ent.pc    = pcF;
        wr_ent.instr = instrF;
`ifdef FDB_ADEL_EN
        wr_ent.adel  = |pcF[1:0];
        if (wr_ent.adel)
            wr_ent.instr = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; everything read out is qualified by validD.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_ent;
    end

    always_comb begin
        pcD      = '0;
        instrD   = '0;
        pcplus4D = '0;
        if (validD) begin
            pcD      = head.pc;
            instrD   = head.instr;
            pcplus4D = head.pc + AW'(4);
        end
    end

`ifdef FDB_ADEL_EN
    assign adelD = validD & head.adel;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer: reset, single pass, stall/full, flush, stream, mid-stream reset.
module tb_fetch_decode_buffer;

    logic        clk;
    logic        rst;
    logic        validF;
    logic        readyF;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        flushD;
    logic        stallD;
    logic        validD;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
`ifdef FDB_ADEL_EN
    logic        adelD;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    fetch_decode_buffer #(.DEPTH(2), .AW(32), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .validF   (validF),
        .readyF   (readyF),
        .pcF      (pcF),
        .instrF   (instrF),
        .flushD   (flushD),
        .stallD   (stallD),
        .validD   (validD),
        .pcD      (pcD),
        .instrD   (instrD),
        .pcplus4D (pcplus4D)
`ifdef FDB_ADEL_EN
        ,
        .adelD    (adelD)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs are changed and outputs sampled 1 unit after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        validF = v;
        pcF    = pc;
        instrF = ins;
    endtask

    initial begin
        rst = 1'b1; flushD = 1'b0; stallD = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // 1: reset
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_validD", {31'b0, validD}, 32'd0);
        chk("rst_instrD", instrD, 32'h0);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_pcplus4D", pcplus4D, 32'h0);
        chk("rst_readyF", {31'b0, readyF}, 32'd1);
`ifdef FDB_ADEL_EN
        chk("rst_adelD", {31'b0, adelD}, 32'd0);
`endif

        // 2: single instruction through
        drive(1'b1, 32'hBFC00000, 32'h24080005);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("one_validD", {31'b0, validD}, 32'd1);
        chk("one_instrD", instrD, 32'h24080005);
        chk("one_pcD", pcD, 32'hBFC00000);
        chk("one_pcplus4D", pcplus4D, 32'hBFC00004);
        step();
        chk("one_popped", {31'b0, validD}, 32'd0);
        chk("one_bubble", instrD, 32'h0);

        // 3: stall, fill, third held by IF, release
        stallD = 1'b1;
        drive(1'b1, 32'h00000100, 32'hA0000001);
        step();
        chk("stall_ready1", {31'b0, readyF}, 32'd1);
        chk("stall_head1", instrD, 32'hA0000001);
        drive(1'b1, 32'h00000104, 32'hA0000002);
        step();
        chk("stall_full", {31'b0, readyF}, 32'd0);
        drive(1'b1, 32'h00000108, 32'hA0000003);
        step();
        chk("stall_hold", instrD, 32'hA0000001);
        chk("stall_still_full", {31'b0, readyF}, 32'd0);
        stallD = 1'b0;
        step();
        chk("rel_e2", instrD, 32'hA0000002);
        chk("rel_ready", {31'b0, readyF}, 32'd1);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("rel_e3", instrD, 32'hA0000003);
        chk("rel_e3_pc", pcD, 32'h00000108);
        step();
        chk("rel_empty", {31'b0, validD}, 32'd0);

        // 4: flush when full, with IF presenting
        stallD = 1'b1;
        drive(1'b1, 32'h00000200, 32'hB0000001);
        step();
        drive(1'b1, 32'h00000204, 32'hB0000002);
        step();
        chk("fl_full", {31'b0, readyF}, 32'd0);
        flushD = 1'b1;
        drive(1'b1, 32'h00000208, 32'hB0000003);
        step();
        flushD = 1'b0;
        stallD = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_validD", {31'b0, validD}, 32'd0);
        chk("fl_readyF", {31'b0, readyF}, 32'd1);
        chk("fl_instrD", instrD, 32'h0);
        step();
        chk("fl_no_ghost", {31'b0, validD}, 32'd0);
        // flush with room: the same-cycle push must be dropped
        flushD = 1'b1;
        drive(1'b1, 32'h0000020C, 32'hB0000004);
        step();
        flushD = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_push_drop", {31'b0, validD}, 32'd0);

        // 5: steady stream, pointers wrap
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h00000400 + 32'(4 * i), 32'h00001000 + 32'(i));
            step();
            chk($sformatf("strm_v%0d", i), {31'b0, validD}, 32'd1);
            chk($sformatf("strm_i%0d", i), instrD, 32'h00001000 + 32'(i));
            chk($sformatf("strm_p4_%0d", i), pcplus4D, 32'h00000404 + 32'(4 * i));
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("strm_drain", {31'b0, validD}, 32'd0);

        // pc+4 wraps modulo 2^32
        drive(1'b1, 32'hFFFFFFFC, 32'h11111111);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("wrap_pcplus4", pcplus4D, 32'h0);
        step();

        // reset mid-stream dominates push and discards entries
        stallD = 1'b1;
        drive(1'b1, 32'h00000600, 32'hC0000001);
        step();
        rst = 1'b1;
        drive(1'b1, 32'h00000604, 32'hC0000002);
        step();
        rst = 1'b0;
        stallD = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("mrst_validD", {31'b0, validD}, 32'd0);
        chk("mrst_readyF", {31'b0, readyF}, 32'd1);
        chk("mrst_pcD", pcD, 32'h0);

`ifdef FDB_ADEL_EN
        // 6: misaligned fetch
        drive(1'b1, 32'hBFC00002, 32'h24080005);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("adel_validD", {31'b0, validD}, 32'd1);
        chk("adel_flag", {31'b0, adelD}, 32'd1);
        chk("adel_instrD", instrD, 32'h0);
        step();
        chk("adel_clear", {31'b0, adelD}, 32'd0);
        drive(1'b1, 32'hBFC00004, 32'h24080006);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("adel_aligned", {31'b0, adelD}, 32'd0);
        chk("adel_aligned_i", instrD, 32'h24080006);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
